div_iter: RTL

Multi-cycle iterative divider for the MIPS DIV/DIVU instructions, sitting in the execute stage alongside the ALU. It accepts operands when a divide enters E, holds the pipeline by driving the `E_div_stall` input of the hazard unit for the duration of the operation, and returns quotient (LO) and remainder (HI) in the cycle the stall drops. It is the producer side of the divide-stall handshake: the hazard unit freezes F/D/E/M while stall is high, so the operands at this block's inputs remain stable for the whole operation.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_iter_if.sv | 29 ++
 rtl/div_step.sv | 32 +++
 rtl/div_iter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative MIPS divider: FSM states and
// width constants.
package div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = $clog2(DIV_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_iter_if.sv
// Execute-stage <-> divider handshake bundle. The pipeline side is the
// master (issues the divide); the divider is the slave.
interface div_iter_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) ();

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             annul;
    logic             div_stall;
    logic             div_done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, dividend, divisor, annul,
        input  div_stall, div_done, hi, lo
    );

    modport slave (
        input  start, is_signed, dividend, divisor, annul,
        output div_stall, div_done, hi, lo
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quot} left, trial-subtract
// the divisor and keep the difference when it does not borrow.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // rem < divisor on entry, so the shifted value fits WIDTH+1 bits and
    // any kept difference fits back into WIDTH bits.
    always_comb begin
        rem_sh = {rem_i, quot_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, divisor_i};
        if (!diff[WIDTH]) begin
            rem_o  = diff[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o  = rem_sh[WIDTH-1:0];
            quot_o = {quot_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle iterative divider for MIPS DIV/DIVU; stalls the pipeline while
// busy and returns quotient on lo, remainder on hi. Optional macro
// DIV_ZERO_FAST_EN finishes a divide by zero straight from IDLE.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic       clk,
    input  logic       rst,
    div_iter_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quot;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        return neg ? -sv : sv;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_sgn);
        return cond_neg(v, is_sgn & v[WIDTH-1]);
    endfunction

    // With a zero divisor every trial subtract succeeds, so after WIDTH steps
    // rem holds the dividend magnitude; re-signing it restores the rs value.
    function automatic logic [2*WIDTH-1:0] fix_up(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic dzero,
                                                  input logic qneg,
                                                  input logic rneg);
        if (dzero) begin
            return {cond_neg(r, rneg), {WIDTH{1'b1}}};
        end
        return {cond_neg(r, rneg), cond_neg(q, qneg)};
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dsr_d   = dsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.annul) begin
                    dsr_d   = magnitude(bus.divisor, bus.is_signed);
                    quot_d  = magnitude(bus.dividend, bus.is_signed);
                    rem_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    qneg_d  = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    rneg_d  = bus.is_signed & bus.dividend[WIDTH-1];
                    state_d = BUSY;
`ifdef DIV_ZERO_FAST_EN
                    if (bus.divisor == '0) begin
                        hi_d    = bus.dividend;
                        lo_d    = '1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                cnt_d  = cnt_q - CNT_W'(1);
                // Results are fixed up and registered on the way into DONE
                // so hi/lo/div_done are flop outputs during the DONE cycle.
                if (cnt_q == CNT_W'(1)) begin
                    {hi_d, lo_d} = fix_up(step_rem, step_quot, dsr_q == '0,
                                          qneg_q, rneg_q);
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.annul) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        quot_q <= quot_d;
        dsr_q  <= dsr_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
    end

    // Combinational so the hazard unit freezes the pipe in the very cycle
    // the divide reaches E.
    assign bus.div_stall = ((state_q == IDLE) && bus.start && !bus.annul)
                         || (state_q == BUSY);
    assign bus.div_done  = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule
